// File: rtl/sqrt_sigcalc_iter.sv
// Iterative radix-2 restoring square-root significand engine: one root bit per cycle, emits {root, sticky}.
// Optional macro SQRT_EXACT_BYPASS_EN: a radicand of exactly 1.0 skips the iteration and completes in one cycle.
module sqrt_sigcalc_iter #(
  parameter int sig_width = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [sig_width-1:0] a_sig,
  input  logic                 a_exp_lsb,
  output logic                 ready,
  output logic                 done,
  output logic [sig_width+2:0] z_sig_nr
);
  localparam int N  = sig_width + 2;
  localparam int RW = N + 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [2*N-1:0]    rad_q, rad_d;
  logic [N-1:0]      root_q, root_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N:0]        z_q, z_d;
  logic              done_q, done_d;

  logic              accept;
  logic [2*N-1:0]    rad_in;
  logic [RW+1:0]     rem_sh, trial;
  logic              fits;

  assign ready    = (state_q != CALC);
  assign done     = done_q;
  assign z_sig_nr = z_q;

  always_comb begin
    accept  = start & ready;
    // Even exponent: the significand is doubled so the root stays in [1,2).
    rad_in  = a_exp_lsb ? {2'b01, a_sig, {N{1'b0}}} : {1'b1, a_sig, 1'b0, {N{1'b0}}};
    rem_sh  = {rem_q, rad_q[2*N-1 -: 2]};
    trial   = {2'b00, root_q, 2'b01};
    fits    = (rem_sh >= trial);

    state_d = state_q;
    rad_d   = rad_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    z_d     = z_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          rad_d   = rad_in;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef SQRT_EXACT_BYPASS_EN
          if (a_exp_lsb && (a_sig == '0)) begin
            state_d = DONE;
            z_d     = {1'b1, {N{1'b0}}};
          end
`endif
        end
      end
      CALC: begin
        // Counter value N marks the extra cycle that publishes the finished root.
        if (cnt_q == CW'(N)) begin
          z_d     = {root_q, |rem_q};
          state_d = DONE;
        end else begin
          rem_d  = fits ? RW'(rem_sh - trial) : rem_sh[RW-1:0];
          root_d = {root_q[N-2:0], fits};
          rad_d  = {rad_q[2*N-3:0], 2'b00};
          cnt_d  = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/sqrt_sigcalc_iter.md
Name: sqrt_sigcalc_iter

Overview:
- Iterative, multi-cycle radix-2 restoring square-root significand engine.
- Sits directly upstream of fp_sqrt's round_gs / exception path, in place of the combinational or pipelined significand calculation.
- Produces the same unrounded root-plus-guard-plus-sticky word that round_gs consumes.
- Trades a fixed latency of sig_width+3 cycles for one adder/comparator.

Parameters:
- sig_width, 23, stored fraction width of the operand; internal root length N = sig_width+2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  clock enable; when 0, all state and outputs hold.
- start  input  1  request; accepted on a rising clk edge when start & ready & enable.
- a_sig  input  sig_width  operand fraction, without the hidden bit.
- a_exp_lsb  input  1  LSB of the biased exponent.
- ready  output  1  high in IDLE and DONE.
- done  output  1  high for exactly the one DONE cycle.
- z_sig_nr  output  sig_width+3  {root[N-1:0], sticky}; root MSB is the hidden bit, root LSB is the guard bit.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, done=0, z_sig_nr=0, root=0, remainder=0, counter=0.
- Radicand R is 2N bits:
  - a_exp_lsb=1: R = {2'b01, a_sig, zeros}.
  - a_exp_lsb=0: R = {1'b1, a_sig, 1'b0, zeros}, i.e. the significand doubled.
  - The exponent half and bias are handled downstream.
- States:
  - IDLE: ready=1. On accept, capture R, clear root/remainder/counter, go to CALC.
  - CALC: ready=0, start ignored. Each enabled cycle:
    - rem' = {rem, next two R bits}
    - trial = {root, 2'b01}
    - if rem' >= trial: rem = rem' - trial, root = {root, 1}; else rem = rem', root = {root, 0}.
    - Counter increments each iteration. After iteration N, load z_sig_nr = {root, |rem} and go to DONE.
  - DONE: done=1, ready=1.
    - Accept in this cycle goes to CALC (back-to-back, no IDLE bubble).
    - Otherwise go to IDLE.
- Widths: remainder is N+2 bits unsigned; no overflow for any input. Root MSB is always 1, because R >= 2^(2N-2).
- Latency: with the start accepted at edge k and enable held high, done is high between edge k+N+1 and edge k+N+2. That is N+1 = sig_width+3 cycles.
- Output hold: z_sig_nr holds its value until the next DONE load; it does not change during CALC.
- enable=0: freezes state, counter, datapath and done. Latency stretches by exactly the number of low cycles.
- Reset in any state: takes priority over enable and start; returns to IDLE with all outputs 0 on the next edge.
- start asserted with enable=0: not accepted.

Optional Feature:
- Macro: SQRT_EXACT_BYPASS_EN.
- Defined: on accept with a_sig==0 and a_exp_lsb==1 (radicand exactly 1.0), skip CALC.
  - Go straight to DONE with z_sig_nr = {1'b1, (N) zeros}.
  - done asserts one cycle after the accept edge.
- Undefined: every operand takes the full N-iteration path. Results are bit-identical with and without the macro; only latency differs.

Test Plan (sig_width=23, N=25):
- Plain root of 1.0: a_sig=0, a_exp_lsb=1, start pulse -> done exactly 26 cycles after the accept edge, z_sig_nr=26'h2000000, ready low throughout CALC.
- Inexact root of 2.0: a_sig=0, a_exp_lsb=0 -> z_sig_nr=26'h2D413CD.
  - Fraction 23'h3504F3, guard=0, sticky=1.
- Exact non-trivial root of 2.25: a_sig=23'h100000, a_exp_lsb=0 -> z_sig_nr=26'h3000000, sticky 0.
- Back-to-back throughput: second start held high during the DONE cycle -> accepted with no bubble; second done 26 cycles later with the correct second result; first z_sig_nr stable until then.
- Stall and reset mid-operation:
  - enable low for 5 cycles mid-CALC -> done at 31 cycles, result unchanged.
  - Separately, reset at iteration 10 -> next cycle IDLE, done=0, z_sig_nr=0, ready=1.
- Bypass macro: with SQRT_EXACT_BYPASS_EN defined, a_sig=0, a_exp_lsb=1 -> done 1 cycle after accept, z_sig_nr=26'h2000000. With the macro undefined, the same stimulus -> 26 cycles.
